pe_array_run_controller: RTL
============================

Name: pe_array_run_controller

Overview:
- Parametrised run sequencer for an array of NUM_PES processing elements; successor to the fixed four-PE control/status aggregation.
- Broadcasts enable/execute through a configurable register pipeline and collects per-PE halted and quiescence flags.
- Sequences launch, run, drain and completion, with a cycle counter, programmable timeout and abort.
- Sits between host control registers and the PE array.

Parameters:
- NUM_PES, 4, number of PEs controlled/monitored (>=1).
- COUNT_WIDTH, 32, width of cycle_count and timeout_limit.
- CONTROL_STAGES, 1, register stages on pe_enable/pe_execute broadcast (>=1).
- QUIESCENT_CYCLES, 4, consecutive all-quiescent sampled cycles required to finish drain (>=1).

Ports:
- clock  in  1  positive-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle run request.
- abort  in  1  abandon current run.
- timeout_limit  in  COUNT_WIDTH  run+drain cycle budget; 0 = no timeout; sampled at start.
- pe_halted  in  NUM_PES  per-PE halted.
- pe_channels_quiescent  in  NUM_PES  per-PE channel buffers empty.
- pe_router_quiescent  in  NUM_PES  per-PE router buffers empty.
- pe_enable  out  1  broadcast enable to all PEs.
- pe_execute  out  1  broadcast execute to all PEs.
- busy  out  1  high in LAUNCH, RUN, DRAIN.
- done  out  1  run completed normally (sticky).
- timed_out  out  1  run ended by timeout (sticky).
- halted_mask  out  NUM_PES  sticky record of PEs seen halted this run.
- cycle_count  out  COUNT_WIDTH  cycles spent in RUN+DRAIN.

Behaviour:
- Reset (reset==0, async): state IDLE; all outputs 0; pipelines, sampled inputs and counters cleared.
- All three per-PE input vectors registered once before use (1-cycle sample latency).
- States: IDLE, LAUNCH, RUN, DRAIN, DONE, TIMEOUT. Internal enable_d = state in {LAUNCH, RUN, DRAIN}; execute_d = (state==RUN). pe_enable/pe_execute are enable_d/execute_d delayed by CONTROL_STAGES flops.
- IDLE/DONE/TIMEOUT + start (abort=0): go to LAUNCH; latch timeout_limit; clear cycle_count, halted_mask, done, timed_out, quiescence counter.
- start ignored while busy.
- LAUNCH: exactly 1 cycle, then RUN.
- RUN:
  - cycle_count += 1 per cycle, saturating at all-ones.
  - halted_mask |= sampled pe_halted.
  - When (halted_mask | sampled pe_halted) is all ones, go to DRAIN.
- DRAIN:
  - cycle_count continues incrementing.
  - Quiescence counter increments when all sampled channel and router flags are 1; it clears to 0 otherwise.
  - When the counter reaches QUIESCENT_CYCLES, go to DONE.
- Timeout: in RUN or DRAIN, when the latched limit != 0 and cycle_count+1 == limit, go to TIMEOUT. cycle_count then equals limit.
- DONE: done=1, busy=0; cycle_count and halted_mask held.
- TIMEOUT: timed_out=1, busy=0; cycle_count and halted_mask held.
- abort: from any busy state, next state IDLE; done=0, timed_out=0; cycle_count/halted_mask held. abort in IDLE/DONE/TIMEOUT clears done/timed_out and goes to IDLE.
- Simultaneous events:
  - abort beats start.
  - Completion (RUN->DRAIN or DRAIN->DONE) beats timeout in the same cycle.
  - Abort beats everything.
- Reset asserted mid-run: immediate return to reset values. pe_enable/pe_execute drop asynchronously, not after CONTROL_STAGES.
- Latency: start at edge t gives LAUNCH at t+1 and pe_enable high at t+1+CONTROL_STAGES. pe_execute rises CONTROL_STAGES cycles after RUN entry and falls CONTROL_STAGES cycles after leaving RUN.

Test Plan:
- Reset/idle (NUM_PES=4, CONTROL_STAGES=1): hold reset low, then release -> all outputs 0, busy=0. start at cycle 0 -> pe_enable=1 at cycle 2, pe_execute=1 at cycle 3.
- Normal run (QUIESCENT_CYCLES=4, timeout_limit=0): PEs halt at staggered cycles 5, 9, 12, 20 with quiescence already high -> halted_mask builds 0001, 0011, 0111, 1111. DRAIN lasts 4 cycles after the last halt, then done=1, busy=0, pe_execute=0.
- Drain glitch: during DRAIN, drop pe_router_quiescent[2] for 1 cycle after 3 quiet cycles -> counter restarts; DONE only after 4 new consecutive quiet cycles.
- Timeout: timeout_limit=10, PE 3 never halts -> timed_out=1, cycle_count=10, halted_mask=0111, pe_enable and pe_execute low CONTROL_STAGES later. New start clears timed_out.
- Abort/start collision: start and abort together in IDLE -> stays IDLE. abort in RUN at count 6 -> IDLE next cycle, cycle_count=6, done=0. start during RUN ignored.
- Boundary: timeout_limit=N and the last PE's halt sampled on the same cycle count reaches N -> DRAIN, not TIMEOUT. Also repeat the normal run with NUM_PES=1, CONTROL_STAGES=3 and confirm pe_enable rises 3 cycles after LAUNCH.

Source files
------------

// File: rtl/pe_array_run_controller.sv
// Run sequencer for a PE array: launch, run, drain, completion,
// with cycle counting, programmable timeout and abort.
module pe_array_run_controller #(
    parameter int NUM_PES          = 4,
    parameter int COUNT_WIDTH      = 32,
    parameter int CONTROL_STAGES   = 1,
    parameter int QUIESCENT_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [COUNT_WIDTH-1:0] timeout_limit,
    input  logic [NUM_PES-1:0]     pe_halted,
    input  logic [NUM_PES-1:0]     pe_channels_quiescent,
    input  logic [NUM_PES-1:0]     pe_router_quiescent,
    output logic                   pe_enable,
    output logic                   pe_execute,
    output logic                   busy,
    output logic                   done,
    output logic                   timed_out,
    output logic [NUM_PES-1:0]     halted_mask,
    output logic [COUNT_WIDTH-1:0] cycle_count
);

    localparam int QW = $clog2(QUIESCENT_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [QW-1:0] Q_ONE  = QW'(1);
    localparam logic [QW-1:0] Q_LAST = QW'(QUIESCENT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_PES-1:0]       halted_s_q;
    logic [NUM_PES-1:0]       chan_s_q;
    logic [NUM_PES-1:0]       rtr_s_q;
    logic [NUM_PES-1:0]       mask_q, mask_d;
    logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0]   limit_q, limit_d;
    logic [COUNT_WIDTH-1:0]   cnt_inc;
    logic [QW-1:0]            qcnt_q, qcnt_d;
    logic                     busy_q, done_q, timed_out_q;
    logic [CONTROL_STAGES-1:0] en_pipe_q, ex_pipe_q;
    logic                     enable_d, execute_d;
    logic                     all_halted, all_quiet, limit_hit;

    // PE status is registered once so nothing downstream sees raw array wires
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            halted_s_q <= '0;
            chan_s_q   <= '0;
            rtr_s_q    <= '0;
        end else begin
            halted_s_q <= pe_halted;
            chan_s_q   <= pe_channels_quiescent;
            rtr_s_q    <= pe_router_quiescent;
        end
    end

    assign all_halted = &(mask_q | halted_s_q);
    assign all_quiet  = &(chan_s_q & rtr_s_q);
    assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign limit_hit  = (limit_q != '0) &&
                        ((cnt_q + CNT_ONE) == limit_q);

    assign enable_d  = (state_q == S_LAUNCH) ||
                       (state_q == S_RUN) ||
                       (state_q == S_DRAIN);
    assign execute_d = (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        qcnt_d  = qcnt_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (start) begin
                        state_d = S_LAUNCH;
                        limit_d = timeout_limit;
                        cnt_d   = '0;
                        mask_d  = '0;
                        qcnt_d  = '0;
                    end
                end
                S_LAUNCH: state_d = S_RUN;
                S_RUN: begin
                    cnt_d  = cnt_inc;
                    mask_d = mask_q | halted_s_q;
                    // completion wins over a coincident timeout
                    if (all_halted) begin
                        state_d = S_DRAIN;
                    end else if (limit_hit) begin
                        state_d = S_TIMEOUT;
                    end
                end
                S_DRAIN: begin
                    cnt_d  = cnt_inc;
                    qcnt_d = all_quiet ? qcnt_q + Q_ONE : '0;
                    if (all_quiet && (qcnt_q == Q_LAST)) begin
                        state_d = S_DONE;
                    end else if (limit_hit) begin
                        state_d = S_TIMEOUT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            cnt_q       <= '0;
            limit_q     <= '0;
            qcnt_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            limit_q     <= limit_d;
            qcnt_q      <= qcnt_d;
            busy_q      <= (state_d == S_LAUNCH) ||
                           (state_d == S_RUN) ||
                           (state_d == S_DRAIN);
            done_q      <= (state_d == S_DONE);
            timed_out_q <= (state_d == S_TIMEOUT);
        end
    end

    // Broadcast pipeline; async reset drops the PE controls immediately
    if (CONTROL_STAGES == 1) begin : g_one_stage
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                en_pipe_q <= '0;
                ex_pipe_q <= '0;
            end else begin
                en_pipe_q <= enable_d;
                ex_pipe_q <= execute_d;
            end
        end
    end else begin : g_multi_stage
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                en_pipe_q <= '0;
                ex_pipe_q <= '0;
            end else begin
                en_pipe_q <= {en_pipe_q[CONTROL_STAGES-2:0], enable_d};
                ex_pipe_q <= {ex_pipe_q[CONTROL_STAGES-2:0], execute_d};
            end
        end
    end

    assign pe_enable   = en_pipe_q[CONTROL_STAGES-1];
    assign pe_execute  = ex_pipe_q[CONTROL_STAGES-1];
    assign busy        = busy_q;
    assign done        = done_q;
    assign timed_out   = timed_out_q;
    assign halted_mask = mask_q;
    assign cycle_count = cnt_q;

endmodule
